// File: rtl/sparse_accum_pkg.sv
// Shared types and constants for the sparse output accumulator.
// Build option SATURATE_EN selects saturating lane adds in sparse_out_accum.
package sparse_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int ERR_RANGE    = 0;
  localparam int ERR_UNINIT   = 1;
  localparam int ERR_DUP_LAST = 2;
  localparam int ERR_SAT      = 3;

  localparam int LANE_W = 32;
  typedef logic signed [LANE_W-1:0] lane_t;

endpackage

// File: rtl/sparse_accum_ram.sv
// Simple dual-port tile RAM: one synchronous write port, one read port with
// 1-cycle latency. Read data holds its value while re is low.
module sparse_accum_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 512,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read-before-write on a same-address collision; the caller forwards.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sparse_out_accum.sv
// Tile output accumulator: overwrite/accumulate tagged result tiles, then drain
// them in tile order. Define SATURATE_EN for saturating lane adds (err_flags[3]).
module sparse_out_accum
  import sparse_accum_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int ACC_W  = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_W:0]        cfg_num_tiles,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_data,
  input  logic [ADDR_W-1:0]      in_tile,
  input  logic                   in_first,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_data,
  output logic [ADDR_W-1:0]      out_tile,
  output logic                   busy,
  output logic                   done_pulse,
  output logic [3:0]             err_flags,
  output logic [1:0]             dbg_state
);

  localparam int DW = LANES * ACC_W;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_e              state_q;
  logic [ADDR_W:0]     num_q;
  logic [ADDR_W:0]     count_q;
  logic [DEPTH-1:0]    written_q;
  logic [DEPTH-1:0]    complete_q;
  logic [3:0]          err_q;

  // S2 pipeline register: beat whose RAM read was issued last cycle
  logic                p_valid_q;
  logic                p_over_q;
  logic [ADDR_W-1:0]   p_tile_q;
  logic [DW-1:0]       p_data_q;
  logic                fwd_hit_q;
  logic [DW-1:0]       fwd_data_q;

  logic [ADDR_W:0]     rd_ptr_q;
  logic                rd_pend_q;
  logic [ADDR_W-1:0]   rd_tile_q;

  logic                all_complete;
  logic                accept;
  logic                in_range;
  logic                s1_go;
  logic                s2_we;
  logic [DW-1:0]       ram_rdata;
  logic [DW-1:0]       old_data;
  logic [DW-1:0]       sum_data;
  logic [DW-1:0]       wr_data;
  logic                dr_load;
  logic                dr_issue;
  logic                last_hs;
  logic                ram_re;
  logic [ADDR_W-1:0]   ram_raddr;
`ifdef SATURATE_EN
  logic                sat_clip;
  logic [ACC_W:0]      ext;
`endif

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // a producer holding valid keeps its payload stable until that edge.
  assign all_complete = (count_q == num_q);
  assign in_ready     = (state_q == ACCUM) && !all_complete && !start;
  assign accept       = in_valid && in_ready;
  assign in_range     = ({1'b0, in_tile} < num_q);
  assign s1_go        = accept && in_range;
  assign s2_we        = p_valid_q && !start;

  assign old_data = fwd_hit_q ? fwd_data_q : ram_rdata;

  always_comb begin
    sum_data = '0;
`ifdef SATURATE_EN
    sat_clip = 1'b0;
    ext      = '0;
`endif
    for (int k = 0; k < LANES; k++) begin
`ifdef SATURATE_EN
      ext = {old_data[k*ACC_W+ACC_W-1], old_data[k*ACC_W +: ACC_W]}
          + {p_data_q[k*ACC_W+ACC_W-1], p_data_q[k*ACC_W +: ACC_W]};
      if (ext[ACC_W] != ext[ACC_W-1]) begin
        sat_clip = 1'b1;
        sum_data[k*ACC_W +: ACC_W] = ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        sum_data[k*ACC_W +: ACC_W] = ext[ACC_W-1:0];
      end
`else
      sum_data[k*ACC_W +: ACC_W] = old_data[k*ACC_W +: ACC_W] + p_data_q[k*ACC_W +: ACC_W];
`endif
    end
  end

  assign wr_data = p_over_q ? p_data_q : sum_data;

  // Drain: a read may issue whenever the read-data slot is free next cycle.
  assign dr_load  = rd_pend_q && (!out_valid || out_ready);
  assign dr_issue = (state_q == DRAIN) && !start && (rd_ptr_q < num_q)
                    && (!rd_pend_q || dr_load);
  assign last_hs  = out_valid && out_ready && ({1'b0, out_tile} == (num_q - ONE));

  assign ram_re    = s1_go || dr_issue;
  assign ram_raddr = (state_q == DRAIN) ? rd_ptr_q[ADDR_W-1:0] : in_tile;

  sparse_accum_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DW),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (s2_we),
    .waddr (p_tile_q),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      num_q      <= '0;
      count_q    <= '0;
      written_q  <= '0;
      complete_q <= '0;
      err_q      <= '0;
      p_valid_q  <= 1'b0;
      p_over_q   <= 1'b0;
      p_tile_q   <= '0;
      p_data_q   <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      rd_ptr_q   <= '0;
      rd_pend_q  <= 1'b0;
      rd_tile_q  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tile   <= '0;
      done_pulse <= 1'b0;
    end else if (start) begin
      state_q    <= (cfg_num_tiles == '0) ? DRAIN : ACCUM;
      num_q      <= cfg_num_tiles;
      count_q    <= '0;
      written_q  <= '0;
      complete_q <= '0;
      err_q      <= '0;
      p_valid_q  <= 1'b0;
      fwd_hit_q  <= 1'b0;
      rd_ptr_q   <= '0;
      rd_pend_q  <= 1'b0;
      out_valid  <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;

      // Bookkeeping depends only on tile/first/last, so it is settled at
      // acceptance; S2 only has to pick overwrite versus add.
      p_valid_q  <= s1_go;
      fwd_hit_q  <= s1_go && p_valid_q && (in_tile == p_tile_q);
      fwd_data_q <= wr_data;
      if (s1_go) begin
        p_tile_q <= in_tile;
        p_data_q <= in_data;
        p_over_q <= in_first || !written_q[in_tile];
        written_q[in_tile] <= 1'b1;
        if (!in_first && !written_q[in_tile]) err_q[ERR_UNINIT] <= 1'b1;
        if (in_last) begin
          if (complete_q[in_tile]) begin
            err_q[ERR_DUP_LAST] <= 1'b1;
          end else begin
            complete_q[in_tile] <= 1'b1;
            count_q             <= count_q + ONE;
          end
        end
      end
      if (accept && !in_range) err_q[ERR_RANGE] <= 1'b1;
`ifdef SATURATE_EN
      if (p_valid_q && !p_over_q && sat_clip) err_q[ERR_SAT] <= 1'b1;
`endif

      if (dr_issue) begin
        rd_ptr_q  <= rd_ptr_q + ONE;
        rd_tile_q <= rd_ptr_q[ADDR_W-1:0];
      end
      rd_pend_q <= dr_issue || (rd_pend_q && !dr_load);
      if (dr_load) begin
        out_valid <= 1'b1;
        out_data  <= ram_rdata;
        out_tile  <= rd_tile_q;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state_q)
        ACCUM: if (all_complete) state_q <= DRAIN;
        DRAIN: begin
          if ((num_q == '0) || last_hs) begin
            state_q    <= IDLE;
            done_pulse <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign err_flags = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sparse_out_accum.sv
// Randomized self-checking bench for sparse_out_accum against a beat-level
// model of the overwrite/accumulate rules and in-order drain.
module tb_sparse_out_accum;
  import sparse_accum_pkg::*;

  localparam int LANES  = 16;
  localparam int ACC_W  = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int DW     = LANES * ACC_W;

  typedef logic [DW-1:0] wide_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   cfg_num_tiles;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic [ADDR_W-1:0] in_tile;
  logic              in_first;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [ADDR_W-1:0] out_tile;
  logic              busy;
  logic              done_pulse;
  logic [3:0]        err_flags;
  logic [1:0]        dbg_state;

  sparse_out_accum #(
    .LANES(LANES), .ACC_W(ACC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_tiles(cfg_num_tiles),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tile(in_tile),
    .in_first(in_first), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tile(out_tile), .busy(busy), .done_pulse(done_pulse),
    .err_flags(err_flags), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  wide_t      mdl_mem[DEPTH];
  bit         mdl_written[DEPTH];
  bit         mdl_complete[DEPTH];
  int         mdl_count;
  int         mdl_num;
  logic [3:0] mdl_err;

  // scoreboard
  logic [ADDR_W-1:0] exp_q[$];
  wide_t             exp_data_q[$];

  task automatic check(input string tag, input wide_t got, input wide_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic wide_t splat(input logic [ACC_W-1:0] v);
    wide_t r;
    for (int k = 0; k < LANES; k++) r[k*ACC_W +: ACC_W] = v;
    return r;
  endfunction

  function automatic wide_t rand_data();
    wide_t r;
    for (int k = 0; k < LANES; k++) r[k*ACC_W +: ACC_W] = $urandom;
    return r;
  endfunction

  function automatic wide_t mdl_add(input wide_t a, input wide_t b, output bit clip);
    wide_t  r;
    longint s;
    longint maxv;
    longint minv;
    maxv = (longint'(1) <<< (ACC_W - 1)) - 1;
    minv = -(longint'(1) <<< (ACC_W - 1));
    clip = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      s = longint'($signed(a[k*ACC_W +: ACC_W])) + longint'($signed(b[k*ACC_W +: ACC_W]));
`ifdef SATURATE_EN
      if (s > maxv) begin s = maxv; clip = 1'b1; end
      else if (s < minv) begin s = minv; clip = 1'b1; end
`endif
      r[k*ACC_W +: ACC_W] = s[ACC_W-1:0];
    end
    return r;
  endfunction

  function automatic logic ready_val(input int mode, input int idx);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      default: return (idx % 4 == 0) || (idx % 4 == 3);
    endcase
  endfunction

  // driver tasks
  task automatic do_start(input int num);
    start         = 1'b1;
    cfg_num_tiles = (ADDR_W+1)'(num);
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < DEPTH; t++) begin
      mdl_written[t]  = 1'b0;
      mdl_complete[t] = 1'b0;
    end
    mdl_count = 0;
    mdl_num   = num;
    mdl_err   = 4'b0;
  endtask

  task automatic send_beat(input int tile, input wide_t data, input bit first, input bit last);
    bit acc;
    bit over;
    bit clip;
    in_valid = 1'b1;
    in_tile  = ADDR_W'(tile);
    in_data  = data;
    in_first = first;
    in_last  = last;
    acc = 1'b0;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    if (!acc) begin
      check("in_ready_timeout", wide_t'(in_ready), wide_t'(1));
      return;
    end
    if (tile >= mdl_num) begin
      mdl_err[ERR_RANGE] = 1'b1;
      return;
    end
    over = first || !mdl_written[tile];
    if (!first && !mdl_written[tile]) mdl_err[ERR_UNINIT] = 1'b1;
    mdl_written[tile] = 1'b1;
    if (over) begin
      mdl_mem[tile] = data;
    end else begin
      mdl_mem[tile] = mdl_add(mdl_mem[tile], data, clip);
      if (clip) mdl_err[ERR_SAT] = 1'b1;
    end
    if (last) begin
      if (mdl_complete[tile]) mdl_err[ERR_DUP_LAST] = 1'b1;
      else begin
        mdl_complete[tile] = 1'b1;
        mdl_count++;
      end
    end
  endtask

  // Called right after the beat that completes the final tile is accepted.
  task automatic drain(input int mode);
    int                cyc;
    bit                last_seen;
    bit                finished;
    bit                prev_stall;
    bit                got_first;
    wide_t             held_d;
    logic [ADDR_W-1:0] held_t;
    exp_q.delete();
    exp_data_q.delete();
    for (int t = 0; t < mdl_num; t++) begin
      exp_q.push_back(ADDR_W'(t));
      exp_data_q.push_back(mdl_mem[t]);
    end
    out_ready  = ready_val(mode, 0);
    cyc        = 0;
    last_seen  = 1'b0;
    finished   = 1'b0;
    prev_stall = 1'b0;
    got_first  = 1'b0;
    held_d     = '0;
    held_t     = '0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (last_seen) begin
        check("done_pulse", wide_t'(done_pulse), wide_t'(1));
        check("busy_after_done", wide_t'(busy), wide_t'(0));
        check("out_valid_after_done", wide_t'(out_valid), wide_t'(0));
        finished = 1'b1;
        break;
      end
      check("done_early", wide_t'(done_pulse), wide_t'(0));
      if (cyc == 1) check("in_ready_fall", wide_t'(in_ready), wide_t'(0));
      if (cyc == 2) check("drain_state", wide_t'(dbg_state), wide_t'(DRAIN));
      if (prev_stall) begin
        check("stall_valid", wide_t'(out_valid), wide_t'(1));
        check("stall_data", out_data, held_d);
        check("stall_tile", wide_t'(out_tile), wide_t'(held_t));
      end
      if (out_valid && !got_first) begin
        got_first = 1'b1;
        check("first_valid_lat", wide_t'(cyc), wide_t'(4));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          check("out_tile", wide_t'(out_tile), wide_t'(exp_q.pop_front()));
          check("out_data", out_data, exp_data_q.pop_front());
        end
        if (exp_q.size() == 0) last_seen = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      held_d     = out_data;
      held_t     = out_tile;
      @(posedge clk); #1;
      out_ready = ready_val(mode, cyc);
    end
    check("drain_finished", wide_t'(finished), wide_t'(1));
    out_ready = 1'b0;
    check("err_flags", wide_t'(err_flags), wide_t'(mdl_err));
  endtask

  initial begin
    int guard;
    int t;
    int done_cyc;
    bit first;
    bit last;

    rst_n = 1'b0; start = 1'b0; cfg_num_tiles = '0;
    in_valid = 1'b0; in_data = '0; in_tile = '0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b0;
    mdl_count = 0; mdl_num = 0; mdl_err = 4'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mdl_mem[i] = '0; mdl_written[i] = 1'b0; mdl_complete[i] = 1'b0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", wide_t'(in_ready), wide_t'(0));
    check("rst_out_valid", wide_t'(out_valid), wide_t'(0));
    check("rst_out_data", out_data, wide_t'(0));
    check("rst_out_tile", wide_t'(out_tile), wide_t'(0));
    check("rst_busy", wide_t'(busy), wide_t'(0));
    check("rst_done", wide_t'(done_pulse), wide_t'(0));
    check("rst_err", wide_t'(err_flags), wide_t'(0));
    check("rst_state", wide_t'(dbg_state), wide_t'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // two tiles, simple overwrite
    do_start(2);
    send_beat(0, splat(32'd5), 1'b1, 1'b1);
    send_beat(1, splat(32'd7), 1'b1, 1'b1);
    drain(0);

    // back-to-back accumulation into one tile
    do_start(4);
    for (int i = 0; i < 3; i++) send_beat(i, rand_data(), 1'b1, 1'b1);
    send_beat(3, splat(32'd1), 1'b1, 1'b0);
    send_beat(3, splat(32'd2), 1'b0, 1'b0);
    send_beat(3, splat(32'd3), 1'b0, 1'b1);
    drain(0);

    // out-of-range tile is dropped
    do_start(4);
    send_beat(5, rand_data(), 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_beat(i, rand_data(), 1'b1, 1'b1);
    drain(0);

    // lane overflow
    do_start(1);
    send_beat(0, splat(32'h7FFF_FFF0), 1'b1, 1'b0);
    send_beat(0, splat(32'h0000_0020), 1'b0, 1'b1);
    drain(0);

    // stalled drain
    do_start(3);
    for (int i = 0; i < 3; i++) send_beat(i, rand_data(), 1'b1, 1'b1);
    drain(2);

    // restart mid-accumulation
    do_start(4);
    send_beat(0, rand_data(), 1'b1, 1'b1);
    send_beat(1, rand_data(), 1'b0, 1'b1);
    send_beat(2, rand_data(), 1'b1, 1'b0);
    @(negedge clk);
    check("pre_restart_err", wide_t'(err_flags), wide_t'(mdl_err));
    @(posedge clk); #1;
    do_start(2);
    @(negedge clk);
    check("restart_err_clear", wide_t'(err_flags), wide_t'(0));
    check("restart_busy", wide_t'(busy), wide_t'(1));
    @(posedge clk); #1;
    send_beat(0, rand_data(), 1'b0, 1'b1);
    send_beat(1, rand_data(), 1'b1, 1'b1);
    drain(1);

    // zero tiles
    do_start(0);
    done_cyc = -1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("zero_out_valid", wide_t'(out_valid), wide_t'(0));
      if (done_pulse && done_cyc < 0) done_cyc = c;
    end
    check("zero_done_lat", wide_t'(done_cyc), wide_t'(2));
    check("zero_busy", wide_t'(busy), wide_t'(0));
    @(posedge clk); #1;

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      do_start($urandom_range(1, 8));
      guard = 0;
      while (mdl_count < mdl_num && guard < 400) begin
        guard++;
        if ($urandom_range(0, 9) == 0) begin
          send_beat($urandom_range(mdl_num, DEPTH - 1), rand_data(), 1'b1, 1'b1);
          continue;
        end
        t = $urandom_range(0, mdl_num - 1);
        if (mdl_complete[t]) begin
          if ($urandom_range(0, 5) == 0) send_beat(t, rand_data(), 1'b0, 1'b1);
          continue;
        end
        first = mdl_written[t] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
        last  = ($urandom_range(0, 2) == 0);
        send_beat(t, rand_data(), first, last);
      end
      drain(r % 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
